// File: rtl/tie_queue_fifo.sv
// Synchronous FIFO linking a producer TIE output queue to a consumer TIE input queue.
// First-word fall-through head; occupancy flags, high-water mark, flush and sticky pop error.
module tie_queue_fifo #(
  parameter int unsigned WIDTH     = 96,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_TH  = 3,
  parameter int unsigned AEMPTY_TH = 1,
  localparam int unsigned LW       = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             BReset,
  input  logic             TIE_OUTQ_PushReq,
  input  logic [WIDTH-1:0] TIE_OUTQ,
  output logic             TIE_OUTQ_Full,
  input  logic             TIE_INQ_PopReq,
  output logic [WIDTH-1:0] TIE_INQ,
  output logic             TIE_INQ_Empty,
  input  logic             Flush,
  output logic [LW-1:0]    Level,
  output logic             AlmostFull,
  output logic             AlmostEmpty,
  output logic [LW-1:0]    HighWater,
  output logic             PopErr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LastIdx   = PW'(DEPTH - 1);
  localparam logic [LW-1:0] DepthLvl  = LW'(DEPTH);
  localparam logic [LW-1:0] AfullLvl  = LW'(AFULL_TH);
  localparam logic [LW-1:0] AemptyLvl = LW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d, hw_q;
  logic             pop_err_q;
  logic [WIDTH-1:0] last_q;
  logic             empty, full, push_acc, pop_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastIdx) ? '0 : p + PW'(1);
  endfunction

  // Flags come from registered level only, never from the request inputs.
  assign empty    = (level_q == '0);
  assign full     = (level_q == DepthLvl);
  assign push_acc = TIE_OUTQ_PushReq && !full;
  assign pop_acc  = TIE_INQ_PopReq && !empty;

  always_comb begin
    level_d = level_q;
    if (Flush) begin
      level_d = '0;
    end else if (push_acc && !pop_acc) begin
      level_d = level_q + LW'(1);
    end else if (pop_acc && !push_acc) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (BReset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      hw_q      <= '0;
      pop_err_q <= 1'b0;
      last_q    <= '0;
    end else begin
      level_q <= level_d;
      if (level_d > hw_q) hw_q <= level_d;
      // Remember the displayed head so the output holds it once the queue drains.
      if (!empty) last_q <= mem[rd_ptr_q];
      if (Flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_acc) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop_acc) rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (TIE_INQ_PopReq && empty) pop_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!BReset && !Flush && push_acc) mem[wr_ptr_q] <= TIE_OUTQ;
  end

  assign TIE_INQ       = empty ? last_q : mem[rd_ptr_q];
  assign TIE_INQ_Empty = empty;
  assign TIE_OUTQ_Full = full;
  assign Level         = level_q;
  assign AlmostFull    = (level_q >= AfullLvl);
  assign AlmostEmpty   = (level_q <= AemptyLvl);
  assign HighWater     = hw_q;
  assign PopErr        = pop_err_q;

endmodule

// File: tb/tb_tie_queue_fifo.sv
// Bench for tie_queue_fifo: DEPTH=4 and DEPTH=5 instances share directed stimulus and are
// checked every cycle against a list-based queue model, plus literal expectations.
module tb_tie_queue_fifo;

  logic        CLK = 1'b0;
  logic        BReset = 1'b1;
  logic        PushReq = 1'b0;
  logic [95:0] din = '0;
  logic        PopReq = 1'b0;
  logic        Flush = 1'b0;

  logic        full4, empty4, af4, ae4, perr4;
  logic [95:0] inq4;
  logic [2:0]  lvl4, hw4;
  logic        full5, empty5, af5, ae5, perr5;
  logic [95:0] inq5;
  logic [2:0]  lvl5, hw5;

  always #5 CLK = ~CLK;

  tie_queue_fifo #(.WIDTH(96), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) u_d4 (
    .CLK(CLK), .BReset(BReset), .TIE_OUTQ_PushReq(PushReq), .TIE_OUTQ(din),
    .TIE_OUTQ_Full(full4), .TIE_INQ_PopReq(PopReq), .TIE_INQ(inq4), .TIE_INQ_Empty(empty4),
    .Flush(Flush), .Level(lvl4), .AlmostFull(af4), .AlmostEmpty(ae4), .HighWater(hw4),
    .PopErr(perr4)
  );

  tie_queue_fifo #(.WIDTH(96), .DEPTH(5), .AFULL_TH(3), .AEMPTY_TH(1)) u_d5 (
    .CLK(CLK), .BReset(BReset), .TIE_OUTQ_PushReq(PushReq), .TIE_OUTQ(din),
    .TIE_OUTQ_Full(full5), .TIE_INQ_PopReq(PopReq), .TIE_INQ(inq5), .TIE_INQ_Empty(empty5),
    .Flush(Flush), .Level(lvl5), .AlmostFull(af5), .AlmostEmpty(ae5), .HighWater(hw5),
    .PopErr(perr5)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Model: ordered list of entries, oldest at index 0.
  logic [95:0] ml [2][8];
  int          cnt [2];
  int          hwm [2];
  bit          perr [2];
  logic [95:0] mlast [2];
  int          dep [2] = '{4, 5};
  bit          mvalid = 1'b0;

  task automatic model_step(input int i);
    bit em, fu, pa, pp;
    if (BReset) begin
      cnt[i] = 0; hwm[i] = 0; perr[i] = 1'b0; mlast[i] = '0;
      return;
    end
    if (cnt[i] > 0) mlast[i] = ml[i][0];
    if (Flush) begin
      cnt[i] = 0;
    end else begin
      em = (cnt[i] == 0);
      fu = (cnt[i] == dep[i]);
      pa = PushReq && !fu;
      pp = PopReq && !em;
      if (PopReq && em) perr[i] = 1'b1;
      if (pp) begin
        for (int k = 0; k < 7; k++) ml[i][k] = ml[i][k+1];
        cnt[i]--;
      end
      if (pa) begin
        ml[i][cnt[i]] = din;
        cnt[i]++;
      end
    end
    if (cnt[i] > hwm[i]) hwm[i] = cnt[i];
  endtask

  always @(posedge CLK) begin
    model_step(0);
    model_step(1);
    if (BReset) mvalid = 1'b1;
  end

  task automatic cmp(input int i, input logic [2:0] lvl, input logic fu, input logic em,
                     input logic af, input logic ae, input logic [2:0] hw, input logic pe,
                     input logic [95:0] inq);
    string p;
    p = $sformatf("d%0d", dep[i]);
    chk({p, ".level"}, 96'(lvl), 96'(cnt[i]));
    chk({p, ".full"}, 96'(fu), 96'(cnt[i] == dep[i]));
    chk({p, ".empty"}, 96'(em), 96'(cnt[i] == 0));
    chk({p, ".afull"}, 96'(af), 96'(cnt[i] >= 3));
    chk({p, ".aempty"}, 96'(ae), 96'(cnt[i] <= 1));
    chk({p, ".highwater"}, 96'(hw), 96'(hwm[i]));
    chk({p, ".poperr"}, 96'(pe), 96'(perr[i]));
    chk({p, ".inq"}, inq, (cnt[i] > 0) ? ml[i][0] : mlast[i]);
  endtask

  always @(negedge CLK) begin
    if (mvalid) begin
      cmp(0, lvl4, full4, empty4, af4, ae4, hw4, perr4, inq4);
      cmp(1, lvl5, full5, empty5, af5, ae5, hw5, perr5, inq5);
    end
  end

  logic [95:0] popped [$];

  // Drive one cycle of inputs at the falling edge; return just after the next rising edge.
  task automatic cyc(input bit push, input logic [95:0] d, input bit pop, input bit fl,
                     input bit rst);
    @(negedge CLK);
    PushReq = push; din = d; PopReq = pop; Flush = fl; BReset = rst;
    if (pop && !empty4 && !fl && !rst) popped.push_back(inq4);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    cyc(0, '0, 0, 0, 1);

    // 1: fill DEPTH=4
    for (int k = 1; k <= 4; k++) cyc(1, 96'(k), 0, 0, 0);
    chk("t1.full", 96'(full4), 96'd1);
    chk("t1.level", 96'(lvl4), 96'd4);
    chk("t1.afull", 96'(af4), 96'd1);
    chk("t1.hw", 96'(hw4), 96'd4);

    // 2: stall while full, then pop frees a slot for 5
    popped.delete();
    for (int k = 0; k < 3; k++) cyc(1, 96'h5, 0, 0, 0);
    chk("t2.level_stall", 96'(lvl4), 96'd4);
    chk("t2.full_stall", 96'(full4), 96'd1);
    cyc(1, 96'h5, 1, 0, 0);
    chk("t2.full_after_pop", 96'(full4), 96'd0);
    chk("t2.level_after_pop", 96'(lvl4), 96'd3);
    cyc(1, 96'h5, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, '0, 1, 0, 0);
    chk("t2.pop_count", 96'(popped.size()), 96'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < popped.size()) chk($sformatf("t2.pop%0d", k), popped[k], 96'(k + 1));
      else chk($sformatf("t2.pop%0d", k), 96'hx, 96'(k + 1));
    end

    // 3: steady push+pop at level 2, wrapping both pointers (DEPTH 4 and 5)
    cyc(0, '0, 0, 0, 1);
    cyc(1, 96'd100, 0, 0, 0);
    cyc(1, 96'd101, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(1, 96'(102 + k), 1, 0, 0);
    chk("t3.d4.level", 96'(lvl4), 96'd2);
    chk("t3.d5.level", 96'(lvl5), 96'd2);
    chk("t3.d4.head", inq4, 96'd120);
    chk("t3.d5.head", inq5, 96'd120);

    // 4: pop while empty
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 1, 0, 0);
    chk("t4.poperr", 96'(perr4), 96'd1);
    chk("t4.level", 96'(lvl4), 96'd0);
    chk("t4.inq", inq4, 96'd0);
    cyc(0, '0, 0, 1, 0);
    chk("t4.poperr_after_flush", 96'(perr4), 96'd1);
    cyc(0, '0, 0, 0, 1);
    chk("t4.poperr_after_reset", 96'(perr4), 96'd0);

    // 5: flush beats simultaneous push and pop
    for (int k = 0; k < 3; k++) cyc(1, 96'(8'h31 + k), 0, 0, 0);
    cyc(1, 96'h34, 1, 1, 0);
    chk("t5.level", 96'(lvl4), 96'd0);
    chk("t5.empty", 96'(empty4), 96'd1);
    chk("t5.hw", 96'(hw4), 96'd3);
    cyc(1, 96'h35, 0, 0, 0);
    chk("t5.next_head", inq4, 96'h35);

    // 6: reset mid-push
    cyc(1, 96'h61, 0, 0, 0);
    cyc(1, 96'h62, 0, 0, 0);
    cyc(1, 96'h77, 0, 0, 1);
    chk("t6.level", 96'(lvl4), 96'd0);
    chk("t6.empty", 96'(empty4), 96'd1);
    chk("t6.full", 96'(full4), 96'd0);
    chk("t6.aempty", 96'(ae4), 96'd1);
    chk("t6.afull", 96'(af4), 96'd0);
    chk("t6.hw", 96'(hw4), 96'd0);
    chk("t6.poperr", 96'(perr4), 96'd0);
    chk("t6.inq", inq4, 96'd0);
    cyc(1, 96'hA, 0, 0, 0);
    chk("t6.readback", inq4, 96'hA);
    cyc(0, '0, 0, 0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
